datapath_param: RTL
===================

# datapath_param

Parametrised multicycle datapath for the albaCore family. It holds the PC, instruction, A/B operand, F result and MDR registers, a 16-entry register file, the ALU, PC-update logic and flag outputs. Each register step is driven by an external control FSM. Compared with the fixed 16-bit generation it adds a configurable data width, a configurable reset PC, asynchronous reset of all state, an iterative multi-cycle shifter with a busy handshake, and a registered carry flag.

## Interface
- W, 16: data/address width in bits; legal values are ≥16. The instruction stays 16 bits.
- RESET_PC, 0: PC value loaded at reset; W bits.

- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- s_addr  in  1  addr select: 0 = pc, 1 = b
- en_inst  in  1  load inst ← din[15:0]
- en_a, en_b  in  1 each  load a ← rf[ra], b ← rf[rb]
- alu_op  in  3  ALU operation (encoding below)
- en_f  in  1  start ALU op / load F; ignored while busy
- en_mdr  in  1  load mdr ← din
- s_regfile_din  in  1  regfile write data: 0 = f, 1 = mdr
- we_regfile  in  1  write rf[rw]
- s_next_pc  in  1  0 = pc+1, 1 = pc+sext(disp)
- en_pc  in  1  load pc ← next_pc
- din  in  W  memory read data
- opcode  out  4  inst[15:12]
- zero, neg  out  1 each  combinational: b==0, b[W-1]
- carry  out  1  registered carry/no-borrow flag
- busy  out  1  shifter in progress
- addr  out  W  memory address
- dout  out  W  memory write data (= a)

## Operation
- Field decode: rw=inst[11:8], ra=inst[7:4], rb=inst[3:0], imm=inst[7:0], disp=inst[11:4], shamt=inst[3:0].
- Register file: 16×W. Write is synchronous. Both reads are asynchronous. Read-during-write to the same entry returns the old value.
- alu_op encoding: 000 ADD a+b; 001 SUB a−b; 010 AND; 011 OR; 100 XOR; 101 LDI = zero-extended imm; 110 SHL a by shamt; 111 SHR (logical) a by shamt. All results are mod 2^W.
- Non-shift ops with en_f=1 and busy=0: f ← result on the next edge.
- carry update on the same edge: ADD loads the carry-out of bit W−1. SUB loads 1 when a ≥ b (unsigned), else 0. All other ops leave carry unchanged.
- Shift ops with en_f=1 and busy=0:
  - The start edge loads f ← a and cnt ← shamt.
  - Each following edge while cnt≠0 does f ← f shifted by 1 in the selected direction (SHL or SHR), and cnt ← cnt−1.
  - Direction is latched at the start edge.
- busy = (cnt≠0), decoded combinationally from the counter.
- While busy=1:
  - en_f is ignored.
  - alu_op changes have no effect.
  - All other enables (a, b, pc, inst, mdr, regfile write) operate normally.
- Writing f to the regfile while busy=1 writes the partial value; the controller must wait for busy=0.
- next_pc: pc+1, or pc + sign-extended 8-bit disp, mod 2^W.
- Simultaneous enables are independent. All registers sample their pre-edge inputs.

## Timing
- Reset values (asynchronous, immediate): pc=RESET_PC; inst, a, b, f, mdr, cnt and carry = 0; all regfile entries = 0.
- Resulting outputs during reset: busy=0, opcode=0, addr=RESET_PC (s_addr=0) or 0, zero=1, neg=0, dout=0.
- Reset asserted mid-shift aborts the shift: f=0, busy=0 immediately.
- Latency of single-cycle ops and register loads: result visible 1 edge after the enable.
- Shift latency: final f is valid after 1+shamt edges from the start edge.
  - busy is high for exactly shamt cycles after the start edge.
  - shamt=0: f=a after 1 edge, busy never asserts.
- Controller handshake: assert en_f for one cycle, then wait until busy=0 before using f.
- zero and neg follow b combinationally, with no extra latency.

## Test plan
- Reset with RESET_PC=16'h0100, then apply en_pc with s_next_pc=0 three times -> pc 0x0100, 0x0101, 0x0102, 0x0103; addr tracks pc.
- r1=0xFFFF, r2=0x0001, then ADD -> f=0x0000, carry=1; then SUB with r1−r2 -> f=0xFFFE, carry=1; then r2−r1 -> f=0x0002, carry=0.
- LDI imm=0xA5 written to r3, then SHL shamt=4 from a=r3 -> busy high 4 cycles, f=0x0A50 on edge 5; a second en_f during busy is ignored.
- W=32, a=0x8000_0000, SHR shamt=15 -> f=0x0001_0000 after 16 edges; reset asserted at cycle 7 -> f=0, busy=0 immediately.
- Branch: pc=0x0010, disp=0xFE, s_next_pc=1 -> pc=0x000E; disp=0x7F -> 0x008D.
- Load path: din=0x1234 with en_mdr, then s_regfile_din=1 and we_regfile to rw=5, then en_b with rb=5 -> b=0x1234, zero=0, neg=0; s_addr=1 -> addr=0x1234.

Source files
------------

// File: rtl/datapath_param_if.sv
// Control and memory bus between the albaCore control FSM (master) and the datapath (slave).
interface datapath_param_if #(
  parameter int W = 16
);
  logic         s_addr;
  logic         en_inst;
  logic         en_a;
  logic         en_b;
  logic [2:0]   alu_op;
  logic         en_f;
  logic         en_mdr;
  logic         s_regfile_din;
  logic         we_regfile;
  logic         s_next_pc;
  logic         en_pc;
  logic [W-1:0] din;

  logic [3:0]   opcode;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         busy;
  logic [W-1:0] addr;
  logic [W-1:0] dout;
  logic [3:0]   dbg_cnt;

  // Handshake: a shift starts on an edge where en_f=1 and busy=0; busy then stays
  // high while the shifter works, en_f is ignored, and f is final once busy=0.
  modport master (
    output s_addr, en_inst, en_a, en_b, alu_op, en_f, en_mdr,
           s_regfile_din, we_regfile, s_next_pc, en_pc, din,
    input  opcode, zero, neg, carry, busy, addr, dout, dbg_cnt
  );

  modport slave (
    input  s_addr, en_inst, en_a, en_b, alu_op, en_f, en_mdr,
           s_regfile_din, we_regfile, s_next_pc, en_pc, din,
    output opcode, zero, neg, carry, busy, addr, dout, dbg_cnt
  );
endinterface

// File: rtl/datapath_param.sv
// Parametrised multicycle albaCore datapath: PC, IR, A/B, F, MDR, 16-entry regfile,
// ALU with registered carry and an iterative one-bit-per-cycle shifter.
module datapath_param #(
  parameter int           W        = 16,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             reset,
  datapath_param_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;

  logic [15:0]  inst;
  logic [W-1:0] pc, a, b, f, mdr;
  logic [3:0]   cnt;
  logic         carry_q;
  logic         shift_left;
  logic [W-1:0] rf [16];

  logic [3:0]   rw, ra, rb, shamt;
  logic [7:0]   imm, disp;
  logic         busy;
  logic [W:0]   sum;
  logic [W-1:0] alu_res;
  logic [W-1:0] next_pc;
  logic         is_shift;

  assign rw    = inst[11:8];
  assign ra    = inst[7:4];
  assign rb    = inst[3:0];
  assign imm   = inst[7:0];
  assign disp  = inst[11:4];
  assign shamt = inst[3:0];

  assign busy     = (cnt != 4'd0);
  assign sum      = {1'b0, a} + {1'b0, b};
  assign is_shift = (bus.alu_op[2:1] == 2'b11);
  assign next_pc  = bus.s_next_pc ? pc + {{(W-8){disp[7]}}, disp}
                                  : pc + {{(W-1){1'b0}}, 1'b1};

  // Shift encodings fall to the default; the shifter loads f from a directly.
  always_comb begin
    alu_res = a;
    case (bus.alu_op)
      OP_ADD:  alu_res = sum[W-1:0];
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_LDI:  alu_res = {{(W-8){1'b0}}, imm};
      default: alu_res = a;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      inst       <= '0;
      a          <= '0;
      b          <= '0;
      f          <= '0;
      mdr        <= '0;
      cnt        <= '0;
      carry_q    <= 1'b0;
      shift_left <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      if (bus.en_pc)      pc   <= next_pc;
      if (bus.en_inst)    inst <= bus.din[15:0];
      if (bus.en_a)       a    <= rf[ra];
      if (bus.en_b)       b    <= rf[rb];
      if (bus.en_mdr)     mdr  <= bus.din;
      if (bus.we_regfile) rf[rw] <= bus.s_regfile_din ? mdr : f;

      // While busy the shifter owns f; en_f and alu_op are not looked at.
      if (busy) begin
        f   <= shift_left ? {f[W-2:0], 1'b0} : {1'b0, f[W-1:1]};
        cnt <= cnt - 4'd1;
      end else if (bus.en_f) begin
        if (is_shift) begin
          f          <= a;
          cnt        <= shamt;
          shift_left <= ~bus.alu_op[0];
        end else begin
          f <= alu_res;
          if (bus.alu_op == OP_ADD) carry_q <= sum[W];
          if (bus.alu_op == OP_SUB) carry_q <= (a >= b);
        end
      end
    end
  end

  assign bus.opcode  = inst[15:12];
  assign bus.zero    = (b == '0);
  assign bus.neg     = b[W-1];
  assign bus.carry   = carry_q;
  assign bus.busy    = busy;
  assign bus.addr    = bus.s_addr ? b : pc;
  assign bus.dout    = a;
  assign bus.dbg_cnt = cnt;
endmodule
